// File: rtl/jlsemi_util_clk_pkg.sv
// Shared types and helpers for the clock-util layer: switch FSM states,
// the minimum divide ratio and the ratio clamp.
package jlsemi_util_clk_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } clk_sw_state_e;

  localparam int unsigned DIV_MIN = 2;

  // Ratios below DIV_MIN cannot form a high and a low phase, so they are raised to DIV_MIN.
  function automatic int unsigned clamp_ratio(input int unsigned field);
    return (field < DIV_MIN) ? DIV_MIN : field;
  endfunction

endpackage

// File: rtl/jlsemi_cell_clk_mux_cell.sv
// Final clock-mux cell: selects the divided clock or the raw clock for DFT.
// Stands in for the hardened library mux in synthesis builds.
module jlsemi_cell_clk_mux_cell (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic z
);

  // Plain two-input select; the library cell provides the glitch-safe implementation.
  assign z = s ? i1 : i0;

endmodule

// File: rtl/jlsemi_util_clkdiv_mux.sv
// Glitch-free programmable clock divider with source selection.
// Ratio/source changes land only on a period boundary; DFT bypasses to clk_i.
module jlsemi_util_clkdiv_mux
  import jlsemi_util_clk_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int DIV_W   = 8,
  parameter int RST_SEL = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_SRC*DIV_W-1:0] div_ratio_i,
  input  logic                     dft_test_clk_en,
  output logic                     clk_o,
  output logic                     clk_en_o,
  output logic [SEL_W-1:0]         sel_active_o,
  output logic                     switch_busy_o
);

  localparam int                 NUM_SLOT  = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]   RST_SEL_W = SEL_W'(RST_SEL);
  localparam logic [SEL_W:0]     NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

  clk_sw_state_e    state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] ratio_cur, ratio_nxt;
  logic [SEL_W-1:0] sel_cur, sel_cur_nxt;
  logic [SEL_W-1:0] sel_pend, sel_pend_nxt;
  logic [SEL_W-1:0] sel_tgt;
  logic             div_q, div_nxt;
  logic             en_q, en_nxt;
  logic             sel_legal;
  logic             wrap;
  logic [DIV_W:0]   half_nxt;
  logic [DIV_W-1:0] ratio_tab [NUM_SLOT];

  // Clamped ratio per selectable index; unused indices read as the minimum ratio.
  always_comb begin
    for (int k = 0; k < NUM_SLOT; k++) ratio_tab[k] = DIV_W'(DIV_MIN);
    for (int k = 0; k < NUM_SRC; k++)
      ratio_tab[k] = DIV_W'(clamp_ratio(32'(div_ratio_i[k*DIV_W +: DIV_W])));
  end

  assign sel_legal = {1'b0, sel_i} < NUM_SRC_W;
  assign wrap      = (cnt == ratio_cur - DIV_W'(1));

  // Next-state: period counter, ratio reload at wrap, switch FSM and DFT override.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_nxt    = state;
    sel_cur_nxt  = sel_cur;
    sel_pend_nxt = sel_pend;
    ratio_nxt    = ratio_cur;
    cnt_nxt      = wrap ? '0 : cnt + DIV_W'(1);
    en_nxt       = wrap;
    sel_tgt      = sel_legal ? sel_i : sel_pend;

    if (dft_test_clk_en) begin
      // Counter parked at 0 so a fresh period starts the moment bypass is released.
      state_nxt    = ST_RUN;
      cnt_nxt      = '0;
      en_nxt       = 1'b1;
      if (sel_legal) sel_cur_nxt = sel_i;
      sel_pend_nxt = sel_cur_nxt;
      ratio_nxt    = ratio_tab[sel_cur_nxt];
    end else begin
      unique case (state)
        ST_RUN: begin
          // A request seen on a wrap cycle waits for the following wrap.
          if (sel_legal && (sel_i != sel_cur)) begin
            state_nxt    = ST_PEND;
            sel_pend_nxt = sel_i;
          end
          if (wrap) ratio_nxt = ratio_tab[sel_cur];
        end
        ST_PEND: begin
          sel_pend_nxt = sel_tgt;
          if (sel_tgt == sel_cur) begin
            state_nxt = ST_RUN;
            if (wrap) ratio_nxt = ratio_tab[sel_cur];
          end else if (wrap) begin
            state_nxt   = ST_RUN;
            sel_cur_nxt = sel_tgt;
            ratio_nxt   = ratio_tab[sel_tgt];
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end

    // High phase first, ceil(R/2) cycles, using the ratio of the period cnt_nxt belongs to.
    half_nxt = ({1'b0, ratio_nxt} + (DIV_W + 1)'(1)) >> 1;
    div_nxt  = ({1'b0, cnt_nxt} < half_nxt);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n_i) begin
      state     <= ST_RUN;
      cnt       <= '0;
      ratio_cur <= DIV_W'(DIV_MIN);
      sel_cur   <= RST_SEL_W;
      sel_pend  <= RST_SEL_W;
      div_q     <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ratio_cur <= ratio_nxt;
      sel_cur   <= sel_cur_nxt;
      sel_pend  <= sel_pend_nxt;
      div_q     <= div_nxt;
      en_q      <= en_nxt;
    end
  end

  assign clk_en_o      = en_q | dft_test_clk_en;
  assign sel_active_o  = sel_cur;
  assign switch_busy_o = (state == ST_PEND) & ~dft_test_clk_en;

`ifdef JL_SYNTHESIS
  jlsemi_cell_clk_mux_cell u_clk_mux (
    .i0 (div_q),
    .i1 (clk_i),
    .s  (dft_test_clk_en),
    .z  (clk_o)
  );
`else
  assign clk_o = dft_test_clk_en ? clk_i : div_q;
`endif

endmodule

// File: tb/tb_jlsemi_util_clkdiv_mux.sv
// Bench for jlsemi_util_clkdiv_mux: a 4-source and a 3-source instance share
// stimulus; a period-level reference model predicts both.
module tb_jlsemi_util_clkdiv_mux;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  sel_i;
  logic [31:0] div_ratio_i;
  logic        dft_test_clk_en;

  logic       clk_o_a, clk_en_a, busy_a;
  logic [1:0] act_a;
  logic       clk_o_b, clk_en_b, busy_b;
  logic [1:0] act_b;

  int checks = 0;
  int errors = 0;
  logic hi_sample;

  always #5 clk_i = ~clk_i;

  jlsemi_util_clkdiv_mux #(.NUM_SRC(4), .SEL_W(2), .DIV_W(8), .RST_SEL(0)) dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sel_i(sel_i), .div_ratio_i(div_ratio_i),
    .dft_test_clk_en(dft_test_clk_en), .clk_o(clk_o_a), .clk_en_o(clk_en_a),
    .sel_active_o(act_a), .switch_busy_o(busy_a));

  jlsemi_util_clkdiv_mux #(.NUM_SRC(3), .SEL_W(2), .DIV_W(8), .RST_SEL(0)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .sel_i(sel_i), .div_ratio_i(div_ratio_i[23:0]),
    .dft_test_clk_en(dft_test_clk_en), .clk_o(clk_o_b), .clk_en_o(clk_en_b),
    .sel_active_o(act_b), .switch_busy_o(busy_b));

  // Reference model: position within the current period, its length, the active
  // source and the pending request (-1 when none).
  int m_pos [2];
  int m_len [2];
  int m_act [2];
  int m_pend[2];
  bit m_clk [2];
  bit m_en  [2];

  function automatic int ratio_of(int k);
    int f;
    f = int'(div_ratio_i[k*8 +: 8]);
    return (f < 2) ? 2 : f;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int ns;
      bit legal;
      bit last;
      ns    = (i == 0) ? 4 : 3;
      legal = int'(sel_i) < ns;
      if (!rst_n_i) begin
        m_pos[i] = 0; m_len[i] = 2; m_act[i] = 0; m_pend[i] = -1;
        m_clk[i] = 1'b0; m_en[i] = 1'b0;
        continue;
      end
      if (dft_test_clk_en) begin
        m_pos[i] = 0; m_pend[i] = -1;
        if (legal) m_act[i] = int'(sel_i);
        m_len[i] = ratio_of(m_act[i]);
        m_clk[i] = 1'b1; m_en[i] = 1'b1;
        continue;
      end
      last = (m_pos[i] == m_len[i] - 1);
      if (m_pend[i] < 0) begin
        if (legal && int'(sel_i) != m_act[i]) m_pend[i] = int'(sel_i);
      end else begin
        if (legal) m_pend[i] = int'(sel_i);
        if (m_pend[i] == m_act[i]) m_pend[i] = -1;
        else if (last) begin
          m_act[i]  = m_pend[i];
          m_pend[i] = -1;
        end
      end
      if (last) begin
        m_pos[i] = 0;
        m_len[i] = ratio_of(m_act[i]);
      end else begin
        m_pos[i] = m_pos[i] + 1;
      end
      m_clk[i] = m_pos[i] < (m_len[i] + 1) / 2;
      m_en[i]  = last;
    end
  endtask

  function automatic logic [4:0] exp_vec(int i);
    if (dft_test_clk_en) return {clk_i, 1'b1, 1'b0, 2'(m_act[i])};
    return {m_clk[i], m_en[i], (m_pend[i] >= 0), 2'(m_act[i])};
  endfunction

  function automatic logic [4:0] got_vec(int i);
    if (i == 0) return {clk_o_a, clk_en_a, busy_a, act_a};
    return {clk_o_b, clk_en_b, busy_b, act_b};
  endfunction

  // One clk_i cycle: model advances at the edge, outputs settle by negedge+1.
  task automatic step();
    @(posedge clk_i);
    model_step();
    #1 hi_sample = clk_o_a;
    @(negedge clk_i);
    #1;
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while (m_pos[0] != target && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (m_pos[0] != target) begin
      errors++;
      $display("FAIL wait_pos: position %0d not reached within 40 cycles", target);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; sel_i = 2'd0; dft_test_clk_en = 1'b0;
    div_ratio_i = {8'd6, 8'd3, 8'd5, 8'd4};
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_vec(i) !== 5'b00000) begin
          errors++;
          $display("FAIL reset[%0d]: got %b want 00000", i, got_vec(i));
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [9:0] want_clk;
    logic [9:0] want_en;
    want_clk = 10'b0110011001;
    want_en  = 10'b0100010001;
    rst_n_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (clk_o_a !== want_clk[9-k] || clk_en_a !== want_en[9-k] || act_a !== 2'd0) begin
        errors++;
        $display("FAIL basic step %0d: clk=%b en=%b act=%0d want clk=%b en=%b act=0",
                 k, clk_o_a, clk_en_a, act_a, want_clk[9-k], want_en[9-k]);
      end
      checks++;
      if (got_vec(1) !== exp_vec(1)) begin
        errors++;
        $display("FAIL basic_b step %0d: got %b want %b", k, got_vec(1), exp_vec(1));
      end
    end
  endtask

  task automatic test_switch();
    int busy_cnt;
    logic [9:0] want_clk;
    want_clk = 10'b1110011100;
    busy_cnt = 0;
    wait_pos(0);
    sel_i = 2'd1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (busy_a) busy_cnt++;
      checks++;
      if (got_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL switch step %0d: got %b want %b", k, got_vec(0), exp_vec(0));
      end
    end
    checks++;
    if (busy_cnt != 3 || act_a !== 2'd1) begin
      errors++;
      $display("FAIL switch_busy: busy cycles %0d act %0d want 3 and 1", busy_cnt, act_a);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (clk_o_a !== want_clk[9-k]) begin
        errors++;
        $display("FAIL switch_shape %0d: clk=%b want %b", k, clk_o_a, want_clk[9-k]);
      end
      step();
    end
  endtask

  task automatic test_retarget();
    wait_pos(0);
    sel_i = 2'd2;
    step();
    sel_i = 2'd3;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (act_a !== 2'd3 || busy_a !== 1'b0 || act_b !== 2'd2 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL retarget: act_a=%0d busy_a=%b act_b=%0d busy_b=%b want 3 0 2 0",
               act_a, busy_a, act_b, busy_b);
    end
    wait_pos(0);
    sel_i = 2'd0;
    step();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL cancel_arm: busy=%b want 1", busy_a);
    end
    sel_i = 2'd3;
    step();
    checks++;
    if (busy_a !== 1'b0 || act_a !== 2'd3) begin
      errors++;
      $display("FAIL cancel: busy=%b act=%0d want 0 and 3", busy_a, act_a);
    end
    checks++;
    if (got_vec(1) !== exp_vec(1)) begin
      errors++;
      $display("FAIL cancel_b: got %b want %b", got_vec(1), exp_vec(1));
    end
  endtask

  task automatic test_clamp();
    logic prev;
    div_ratio_i = {8'd6, 8'd0, 8'd5, 8'd1};
    sel_i = 2'd0;
    for (int k = 0; k < 14; k++) step();
    for (int j = 0; j < 2; j++) begin
      prev = clk_o_a;
      for (int k = 0; k < 6; k++) begin
        step();
        checks++;
        if (clk_o_a === prev || act_a !== 2'(j * 2)) begin
          errors++;
          $display("FAIL clamp src%0d: clk=%b prev=%b act=%0d", j * 2, clk_o_a, prev, act_a);
        end
        prev = clk_o_a;
      end
      sel_i = 2'd2;
      for (int k = 0; k < 4; k++) step();
    end
    sel_i = 2'd3;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (act_b !== 2'd2 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL out_of_range: act_b=%0d busy_b=%b want 2 0", act_b, busy_b);
      end
    end
  endtask

  task automatic test_dft();
    wait_pos(0);
    sel_i = 2'd1;
    step();
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL dft_pre: busy=%b want 1", busy_a);
    end
    dft_test_clk_en = 1'b1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || clk_en_a !== 1'b1 || clk_o_a !== clk_i) begin
      errors++;
      $display("FAIL dft_enter: busy=%b en=%b clk_o=%b clk_i=%b", busy_a, clk_en_a, clk_o_a, clk_i);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (hi_sample !== 1'b1 || clk_o_a !== 1'b0 || clk_en_a !== 1'b1 ||
          busy_a !== 1'b0 || act_a !== 2'd1) begin
        errors++;
        $display("FAIL dft step %0d: hi=%b lo=%b en=%b busy=%b act=%0d", k,
                 hi_sample, clk_o_a, clk_en_a, busy_a, act_a);
      end
    end
    dft_test_clk_en = 1'b0;
    #1;
    checks++;
    if (clk_o_a !== 1'b1 || clk_en_a !== 1'b1 || got_vec(0) !== exp_vec(0)) begin
      errors++;
      $display("FAIL dft_exit: clk=%b en=%b got %b want %b", clk_o_a, clk_en_a,
               got_vec(0), exp_vec(0));
    end
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (got_vec(0) !== exp_vec(0)) begin
        errors++;
        $display("FAIL dft_after %0d: got %b want %b", k, got_vec(0), exp_vec(0));
      end
    end
  endtask

  task automatic test_rst_mid();
    int n;
    sel_i = 2'd3;
    n = 0;
    while (m_act[0] != 3 && n < 20) begin
      step();
      n++;
    end
    wait_pos(2);
    sel_i = 2'd0;
    step();
    checks++;
    if (busy_a !== 1'b1 || act_a !== 2'd3) begin
      errors++;
      $display("FAIL rst_mid_pre: busy=%b act=%0d want 1 and 3", busy_a, act_a);
    end
    rst_n_i = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_vec(i) !== 5'b00000) begin
        errors++;
        $display("FAIL rst_mid[%0d]: got %b want 00000", i, got_vec(i));
      end
    end
    rst_n_i = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) sel_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        div_ratio_i[$urandom_range(0, 3)*8 +: 8] = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 39) == 0) dft_test_clk_en = ~dft_test_clk_en;
      rst_n_i = ($urandom_range(0, 99) != 0);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_vec(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got %b want %b", i, k, got_vec(i), exp_vec(i));
        end
      end
    end
    dft_test_clk_en = 1'b0;
    rst_n_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = 0; m_len[i] = 2; m_act[i] = 0; m_pend[i] = -1;
      m_clk[i] = 1'b0; m_en[i] = 1'b0;
    end
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_switch();
    test_retarget();
    test_clamp();
    test_dft();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
